float_fix_scheduler: RTL and testbench

Shares one combinational float-to-fixed converter between two requesters (A, B). The block runs round-robin arbitration, latches the winner's operands onto the converter inputs, holds them for a programmable settle time, and captures the converter output. It saturates out-of-range conversions and returns the result through a valid/ready response port tagged with the requester ID. It sits between the requesting datapaths and the shared converter instance.

---
 rtl/float_fix_scheduler.sv | 149 ++++++++++++++
 tb/tb_float_fix_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_fix_scheduler.sv
// Round-robin scheduler sharing one combinational float-to-fixed converter
// between requesters A and B, with settle hold, saturation and tagged response.
//
// state  | meaning
// IDLE   | arbitrate between A and B, accept one operand
// SETTLE | operand held on converter, count down settle time
// RESP   | response registered, wait for consumer handshake
module float_fix_scheduler #(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        a_valid_i,
    output logic        a_ready_o,
    input  logic [31:0] a_float_i,
    input  logic [4:0]  a_pos_i,
    input  logic        b_valid_i,
    output logic        b_ready_o,
    input  logic [31:0] b_float_i,
    input  logic [4:0]  b_pos_i,
    output logic [31:0] conv_float_o,
    output logic [4:0]  conv_pos_o,
    input  logic [31:0] conv_result_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_data_o,
    output logic        resp_id_o,
    output logic        resp_ovf_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_M1 = 4'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_id_q, last_id_d;
    logic [31:0] conv_float_q, conv_float_d;
    logic [4:0]  conv_pos_q, conv_pos_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_id_q, resp_id_d;
    logic        resp_ovf_q, resp_ovf_d;

    logic        in_idle;
    logic        grant_a, grant_b;
    logic [7:0]  exp_f;
    logic [8:0]  exp_sum;
    logic        is_zero, is_sat;

    // Ready is held low while reset is asserted so every output reads 0 in reset.
    assign in_idle   = (state_q == IDLE) & rst_ni;
    assign grant_a   = a_valid_i & (~b_valid_i | last_id_q);
    assign grant_b   = b_valid_i & ~grant_a;
    assign a_ready_o = in_idle & grant_a;
    assign b_ready_o = in_idle & grant_b;

    // e - 127 + pos > 30 rewritten in biased form: e + pos > 157, 9 bits never wrap.
    assign exp_f   = conv_float_q[30:23];
    assign exp_sum = {1'b0, exp_f} + {4'b0, conv_pos_q};
    assign is_zero = (exp_f == 8'h00);
    assign is_sat  = (exp_f == 8'hFF) | (exp_sum > 9'd157);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_id_d    = last_id_q;
        conv_float_d = conv_float_q;
        conv_pos_d   = conv_pos_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        resp_ovf_d   = resp_ovf_q;

        case (state_q)
            IDLE: begin
                if (grant_a | grant_b) begin
                    conv_float_d = grant_a ? a_float_i : b_float_i;
                    conv_pos_d   = grant_a ? a_pos_i : b_pos_i;
                    last_id_d    = grant_b;
                    cnt_d        = HOLD_M1;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = last_id_q;
                    if (is_zero) begin
                        resp_data_d = 32'h0000_0000;
                        resp_ovf_d  = 1'b0;
                    end else if (is_sat) begin
                        resp_data_d = conv_float_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        resp_ovf_d  = 1'b1;
                    end else begin
                        resp_data_d = conv_result_i;
                        resp_ovf_d  = 1'b0;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_id_q    <= 1'b1;
            conv_float_q <= 32'h0;
            conv_pos_q   <= 5'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0;
            resp_id_q    <= 1'b0;
            resp_ovf_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_id_q    <= last_id_d;
            conv_float_q <= conv_float_d;
            conv_pos_q   <= conv_pos_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            resp_ovf_q   <= resp_ovf_d;
        end
    end

    assign conv_float_o = conv_float_q;
    assign conv_pos_o   = conv_pos_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_id_o    = resp_id_q;
    assign resp_ovf_o   = resp_ovf_q;

endmodule

// File: tb/tb_float_fix_scheduler.sv
// Bench for float_fix_scheduler: vector table, arbitration/backpressure/reset
// sequences, and randomized traffic against a transaction-level model.
module tb_float_fix_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int checks = 0;
    int failures = 0;

    // HOLD_CYCLES = 1 instance
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [31:0] a_float, b_float, conv_float, conv_result, resp_data;
    logic [4:0]  a_pos, b_pos, conv_pos;
    logic        resp_valid, resp_ready, resp_id, resp_ovf;

    // HOLD_CYCLES = 4 instance
    logic        a4_valid, a4_ready, b4_valid, b4_ready;
    logic [31:0] a4_float, b4_float, conv4_float, conv4_result, resp4_data;
    logic [4:0]  a4_pos, b4_pos, conv4_pos;
    logic        resp4_valid, resp4_ready, resp4_id, resp4_ovf;

    // Converter model: truncating float * 2^pos, two's complement result.
    function automatic logic [31:0] conv_model(input logic [31:0] f, input logic [4:0] p);
        longint m, mag;
        int sh;
        if (f[30:23] == 8'h00) return 32'h0;
        m  = longint'({1'b1, f[22:0]});
        sh = int'(f[30:23]) - 127 + int'(p) - 23;
        if (sh > 40) sh = 40;
        mag = (sh >= 0) ? (m << sh) : (m >> (-sh));
        return f[31] ? 32'(-mag) : 32'(mag);
    endfunction

    assign conv_result  = conv_model(conv_float, conv_pos);
    assign conv4_result = conv_model(conv4_float, conv4_pos);

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        ovf;
    } exp_t;

    function automatic exp_t ref_result(input logic id, input logic [31:0] f, input logic [4:0] p);
        exp_t r;
        int unbiased;
        r.id = id;
        unbiased = int'(f[30:23]) - 127;
        if (f[30:23] == 8'd0) begin
            r.data = 32'h0; r.ovf = 1'b0;
        end else if (f[30:23] == 8'd255 || unbiased + int'(p) > 30) begin
            r.data = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF; r.ovf = 1'b1;
        end else begin
            r.data = conv_model(f, p); r.ovf = 1'b0;
        end
        return r;
    endfunction

    float_fix_scheduler #(.HOLD_CYCLES(1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .a_valid_i(a_valid), .a_ready_o(a_ready), .a_float_i(a_float), .a_pos_i(a_pos),
        .b_valid_i(b_valid), .b_ready_o(b_ready), .b_float_i(b_float), .b_pos_i(b_pos),
        .conv_float_o(conv_float), .conv_pos_o(conv_pos), .conv_result_i(conv_result),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
        .resp_id_o(resp_id), .resp_ovf_o(resp_ovf)
    );

    float_fix_scheduler #(.HOLD_CYCLES(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .a_valid_i(a4_valid), .a_ready_o(a4_ready), .a_float_i(a4_float), .a_pos_i(a4_pos),
        .b_valid_i(b4_valid), .b_ready_o(b4_ready), .b_float_i(b4_float), .b_pos_i(b4_pos),
        .conv_float_o(conv4_float), .conv_pos_o(conv4_pos), .conv_result_i(conv4_result),
        .resp_valid_o(resp4_valid), .resp_ready_i(resp4_ready), .resp_data_o(resp4_data),
        .resp_id_o(resp4_id), .resp_ovf_o(resp4_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Present one operand to the H=1 instance; returns edges from accept to resp_valid.
    task automatic send1(input logic who, input logic [31:0] f, input logic [4:0] p, output int lat);
        int n;
        if (!who) begin a_valid = 1'b1; a_float = f; a_pos = p; end
        else      begin b_valid = 1'b1; b_float = f; b_pos = p; end
        n = 0;
        @(negedge clk);
        while (!(who ? b_ready : a_ready) && n < 50) begin @(negedge clk); n++; end
        chk("send_grant_in_time", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_float();
        logic [7:0] e;
        case ($urandom % 8)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            default: e = 8'($urandom_range(110, 165));
        endcase
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    typedef struct {
        logic [31:0] f;
        logic [4:0]  p;
        logic [31:0] d;
        logic        o;
    } vec_t;

    vec_t tbl[8];
    exp_t q[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bad;
        int gcnt, rcnt, last_g;
        logic [31:0] gid[4], gcyc[4], rid[4], rdat[4];
        logic [31:0] hd;
        logic hid, hov;
        logic ga, gb, mbusy, mlast;
        exp_t e;

        tbl[0] = '{32'h40A0_0000, 5'd4,  32'h0000_0050, 1'b0};
        tbl[1] = '{32'h4F00_0000, 5'd0,  32'h7FFF_FFFF, 1'b1};
        tbl[2] = '{32'hCF00_0000, 5'd0,  32'h8000_0000, 1'b1};
        tbl[3] = '{32'h7FC0_0000, 5'd0,  32'h7FFF_FFFF, 1'b1};
        tbl[4] = '{32'h0000_0000, 5'd0,  32'h0000_0000, 1'b0};
        tbl[5] = '{32'h3F80_0000, 5'd30, 32'h4000_0000, 1'b0};
        tbl[6] = '{32'h3F80_0000, 5'd31, 32'h7FFF_FFFF, 1'b1};
        tbl[7] = '{32'hBF80_0000, 5'd3,  32'hFFFF_FFF8, 1'b0};

        a_valid = 0; b_valid = 0; a_float = 0; b_float = 0; a_pos = 0; b_pos = 0;
        resp_ready = 1;
        a4_valid = 0; b4_valid = 0; a4_float = 0; b4_float = 0; a4_pos = 0; b4_pos = 0;
        resp4_ready = 1;

        // reset state, with a request pending to show ready stays low
        rst_n = 1'b0;
        a_valid = 1'b1;
        #12;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_conv_float", conv_float, 0);
        chk("rst_conv_pos", conv_pos, 0);
        chk("rst_resp_id_ovf", {resp_id, resp_ovf}, 0);
        a_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // vector table, alternating requesters
        for (int i = 0; i < 8; i++) begin
            send1(1'(i % 2), tbl[i].f, tbl[i].p, lat);
            chk("vec_latency", lat, 1);
            chk("vec_data", resp_data, tbl[i].d);
            chk("vec_ovf", resp_ovf, tbl[i].o);
            chk("vec_id", resp_id, 32'(i % 2));
            @(posedge clk); #1;
            chk("vec_resp_drop", resp_valid, 0);
        end

        // tie after reset: A,B,A,B at one grant per HOLD+2 cycles
        do_reset();
        a_float = 32'h3F80_0000; a_pos = 0; b_float = 32'h4000_0000; b_pos = 0;
        a_valid = 1; b_valid = 1; resp_ready = 1;
        bad = 0; gcnt = 0; rcnt = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (a_ready && b_ready) bad++;
            if ((a_ready || b_ready) && gcnt < 4) begin gid[gcnt] = 32'(b_ready); gcyc[gcnt] = c; gcnt++; end
            if (resp_valid && resp_ready && rcnt < 4) begin rid[rcnt] = 32'(resp_id); rdat[rcnt] = resp_data; rcnt++; end
        end
        a_valid = 0; b_valid = 0;
        chk("tie_both_ready", bad, 0);
        chk("tie_grant_count", gcnt, 4);
        chk("tie_resp_count", rcnt, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < gcnt) chk("tie_grant_order", gid[i], 32'(i % 2));
            if (i > 0 && i < gcnt) chk("tie_grant_gap", gcyc[i] - gcyc[i-1], 3);
            if (i < rcnt) chk("tie_resp_id", rid[i], 32'(i % 2));
            if (i < rcnt) chk("tie_resp_data", rdat[i], (i % 2) ? 32'd2 : 32'd1);
        end
        repeat (6) @(posedge clk);
        #1;

        // backpressure
        resp_ready = 0;
        send1(0, 32'h40A0_0000, 5'd4, lat);
        chk("bp_latency", lat, 1);
        hd = resp_data; hid = resp_id; hov = resp_ovf;
        chk("bp_data", hd, 32'h50);
        a_valid = 1; a_float = 32'h3F80_0000; a_pos = 0;
        b_valid = 1; b_float = 32'h4000_0000; b_pos = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_ready_low", {a_ready, b_ready}, 0);
            chk("bp_valid_held", resp_valid, 1);
            chk("bp_data_stable", resp_data, hd);
            chk("bp_tag_stable", {resp_id, resp_ovf}, {hid, hov});
        end
        @(posedge clk); #1;
        resp_ready = 1;
        @(negedge clk);
        chk("bp_handshake_no_ready", {a_ready, b_ready}, 0);
        @(posedge clk); #1;
        chk("bp_resp_drop", resp_valid, 0);
        @(negedge clk);
        chk("bp_next_grant_b", {a_ready, b_ready}, 2'b01);
        @(posedge clk); #1;
        a_valid = 0; b_valid = 0;
        lat = 0;
        while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("bp_b_latency", lat, 1);
        chk("bp_b_id", resp_id, 1);
        chk("bp_b_data", resp_data, 32'd2);
        @(posedge clk); #1;

        // HOLD_CYCLES=4, accept from B
        b4_valid = 1; b4_float = 32'h40A0_0000; b4_pos = 4;
        lat = 0;
        @(negedge clk);
        while (!b4_ready && lat < 50) begin @(negedge clk); lat++; end
        chk("h4_grant_in_time", 32'(lat < 50), 1);
        @(posedge clk); #1;
        b4_valid = 0; b4_float = 32'h0; b4_pos = 0;
        lat = 0;
        while (!resp4_valid && lat < 50) begin
            chk("h4_conv_stable", {conv4_pos, conv4_float[26:0]}, {5'd4, 27'h0A0_0000});
            chk("h4_conv_float", conv4_float, 32'h40A0_0000);
            @(posedge clk); #1; lat++;
        end
        chk("h4_latency", lat, 4);
        chk("h4_id", resp4_id, 1);
        chk("h4_data", resp4_data, 32'h50);
        @(posedge clk); #1;

        // async reset mid-SETTLE on the H=4 instance
        a4_valid = 1; a4_float = 32'hC000_0000; a4_pos = 2;
        @(posedge clk); #1;
        a4_valid = 0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_conv_float", conv4_float, 0);
        chk("mid_rst_conv_pos", conv4_pos, 0);
        chk("mid_rst_resp", {resp4_valid, resp4_id, resp4_ovf}, 0);
        chk("mid_rst_resp_data", resp4_data, 0);
        chk("mid_rst_ready", {a4_ready, b4_ready}, 0);
        @(negedge clk); rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin @(negedge clk); if (resp4_valid) bad++; end
        chk("mid_rst_no_stale", bad, 0);
        @(posedge clk); #1;
        a4_valid = 1; b4_valid = 1;
        @(negedge clk);
        chk("mid_rst_tie_a", {a4_ready, b4_ready}, 2'b10);
        @(posedge clk); #1;
        a4_valid = 0; b4_valid = 0;

        // randomized traffic on the H=1 instance (untouched since reset, last winner = B)
        mbusy = 0; mlast = 1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            ga = !mbusy && a_valid && (!b_valid || mlast);
            gb = !mbusy && b_valid && !ga;
            chk("rnd_a_ready", a_ready, ga);
            chk("rnd_b_ready", b_ready, gb);
            if (ga) q.push_back(ref_result(1'b0, a_float, a_pos));
            if (gb) q.push_back(ref_result(1'b1, b_float, b_pos));
            if (ga || gb) begin mbusy = 1; mlast = gb; end
            if (resp_valid && resp_ready) begin
                chk("rnd_resp_expected", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("rnd_id", resp_id, e.id);
                    chk("rnd_data", resp_data, e.data);
                    chk("rnd_ovf", resp_ovf, e.ovf);
                end
                mbusy = 0;
            end
            @(posedge clk); #1;
            if (ga || !a_valid) begin
                a_valid = 1'($urandom);
                a_float = rand_float(); a_pos = 5'($urandom);
            end
            if (gb || !b_valid) begin
                b_valid = 1'($urandom);
                b_float = rand_float(); b_pos = 5'($urandom);
            end
            resp_ready = ($urandom % 4) != 0;
        end
        a_valid = 0; b_valid = 0; resp_ready = 1;
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
